// File: rtl/g15_key_pkg.sv
// g15_key_pkg
// Shared types and parameter legality check for the G-15 key conditioner.
//   kc_state_t    : per-channel FSM state
//   kc_params_ok  : elaboration-time check of N_CH / DEBOUNCE_MS / HOLD_MS / CNT_W
package g15_key_pkg;

   typedef enum logic [1:0] {KC_IDLE, KC_QUAL, KC_ACTIVE, KC_RELEASE} kc_state_t;

   // Counter must be able to reach the larger of the two tick thresholds.
   function automatic bit kc_params_ok(int n_ch, int deb, int hold, int cnt_w);
      int mx;
      mx = (deb > hold) ? deb : hold;
      return (n_ch >= 1) && (n_ch <= 32) && (deb >= 1) && (hold >= 1) &&
             (cnt_w >= 1) && (cnt_w <= 30) && ((1 << cnt_w) > mx);
   endfunction

endpackage

// File: rtl/g15_key_conditioner_if.sv
// g15_key_conditioner_if
// Bundle between the raw key pins / tick source and the I/O logic.
//   tick_ms      : one-CLOCK pulse per millisecond
//   raw_in       : asynchronous contacts, 1 = closed
//   mode_oneshot : per-channel mode, 1 = one-shot, 0 = level
//   key_out      : conditioned key level
//   key_edge     : one-cycle strobe on key_out rise
//   busy         : any channel away from IDLE
// master = pin/tick side, slave = conditioner.
interface g15_key_conditioner_if #(parameter int N_CH = 16);

   logic            tick_ms;
   logic [N_CH-1:0] raw_in;
   logic [N_CH-1:0] mode_oneshot;
   logic [N_CH-1:0] key_out;
   logic [N_CH-1:0] key_edge;
   logic            busy;

   modport master (output tick_ms, raw_in, mode_oneshot,
                   input  key_out, key_edge, busy);
   modport slave  (input  tick_ms, raw_in, mode_oneshot,
                   output key_out, key_edge, busy);

endinterface

// File: rtl/g15_key_channel.sv
// g15_key_channel
// One key channel: 2-flop synchroniser, debounce / one-shot FSM, tick counter.
//   CLOCK, rst : clock, async active-high reset
//   i_tick     : millisecond tick
//   i_raw      : asynchronous contact
//   i_mode     : mode, sampled only on IDLE -> QUAL
//   o_key      : registered (state == ACTIVE)
//   o_edge     : one-cycle strobe on o_key rise
//   o_busy     : state != IDLE
module g15_key_channel import g15_key_pkg::*; #(
   parameter int DEBOUNCE_MS = 5,
   parameter int HOLD_MS     = 50,
   parameter int CNT_W       = 6
) (
   input  logic CLOCK,
   input  logic rst,
   input  logic i_tick,
   input  logic i_raw,
   input  logic i_mode,
   output logic o_key,
   output logic o_edge,
   output logic o_busy
);

   localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEBOUNCE_MS);
   localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MS);

   logic [1:0]       r_sync;
   logic             w_s;
   kc_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_inc;
   logic             r_mode_q;
   logic             r_key;
   logic             r_edge;

   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) r_sync <= 2'b00;
      else     r_sync <= {r_sync[0], i_raw};
   end
   assign w_s = r_sync[1];

   // Saturating increment; thresholds are compared against the post-tick value.
   assign w_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) begin
         r_state  <= KC_IDLE;
         r_cnt    <= '0;
         r_mode_q <= 1'b0;
         r_key    <= 1'b0;
         r_edge   <= 1'b0;
      end else begin
         r_edge <= 1'b0;
         case (r_state)
            KC_IDLE: begin
               if (w_s) begin
                  r_state  <= KC_QUAL;
                  r_cnt    <= '0;
                  r_mode_q <= i_mode;
               end
            end
            KC_QUAL: begin
               if (!w_s) begin
                  r_state <= KC_IDLE;
                  r_cnt   <= '0;
               end else if (i_tick) begin
                  if (w_inc == DEB_C) begin
                     r_state <= KC_ACTIVE;
                     r_cnt   <= '0;
                     r_key   <= 1'b1;
                     r_edge  <= 1'b1;
                  end else begin
                     r_cnt <= w_inc;
                  end
               end
            end
            KC_ACTIVE: begin
               if (r_mode_q) begin
                  // One-shot: contact ignored, fixed width then lockout.
                  if (i_tick) begin
                     if (w_inc == HOLD_C) begin
                        r_state <= KC_RELEASE;
                        r_cnt   <= '0;
                        r_key   <= 1'b0;
                     end else begin
                        r_cnt <= w_inc;
                     end
                  end
               end else if (w_s) begin
                  r_cnt <= '0;
               end else if (i_tick) begin
                  if (w_inc == DEB_C) begin
                     r_state <= KC_IDLE;
                     r_cnt   <= '0;
                     r_key   <= 1'b0;
                  end else begin
                     r_cnt <= w_inc;
                  end
               end
            end
            KC_RELEASE: begin
               // Held key stays here; only a debounced release rearms.
               if (w_s) begin
                  r_cnt <= '0;
               end else if (i_tick) begin
                  if (w_inc == DEB_C) begin
                     r_state <= KC_IDLE;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= w_inc;
                  end
               end
            end
            default: r_state <= KC_IDLE;
         endcase
      end
   end

   assign o_key  = r_key;
   assign o_edge = r_edge;
   assign o_busy = (r_state != KC_IDLE);

endmodule

// File: rtl/g15_key_conditioner.sv
// g15_key_conditioner
// N_CH independent key channels between raw G-15 key/switch pins and I/O logic.
//   CLOCK, rst : clock, async active-high reset
//   bus        : g15_key_conditioner_if.slave (tick, contacts, modes in;
//                key_out, key_edge, busy out)
module g15_key_conditioner import g15_key_pkg::*; #(
   parameter int N_CH        = 16,
   parameter int DEBOUNCE_MS = 5,
   parameter int HOLD_MS     = 50,
   parameter int CNT_W       = 6
) (
   input logic                   CLOCK,
   input logic                   rst,
   g15_key_conditioner_if.slave  bus
);

   logic [N_CH-1:0] w_key;
   logic [N_CH-1:0] w_edge;
   logic [N_CH-1:0] w_busy;

   if (!kc_params_ok(N_CH, DEBOUNCE_MS, HOLD_MS, CNT_W)) begin : g_bad_params
      $error("g15_key_conditioner: illegal N_CH/DEBOUNCE_MS/HOLD_MS/CNT_W");
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      g15_key_channel #(
         .DEBOUNCE_MS (DEBOUNCE_MS),
         .HOLD_MS     (HOLD_MS),
         .CNT_W       (CNT_W)
      ) u_ch (
         .CLOCK  (CLOCK),
         .rst    (rst),
         .i_tick (bus.tick_ms),
         .i_raw  (bus.raw_in[gi]),
         .i_mode (bus.mode_oneshot[gi]),
         .o_key  (w_key[gi]),
         .o_edge (w_edge[gi]),
         .o_busy (w_busy[gi])
      );
   end

   assign bus.key_out  = w_key;
   assign bus.key_edge = w_edge;
   assign bus.busy     = |w_busy;

endmodule

// File: tb/tb_g15_key_conditioner.sv
// tb_g15_key_conditioner
// Scoreboard bench: each press/release pushes the expected key_out rise/fall
// cycle per channel; a per-cycle monitor pops and compares on every observed
// key_out transition. Ticks land on edges that are multiples of 100.
module tb_g15_key_conditioner;

   localparam int NCH = 4;

   typedef struct {
      int cyc;
      bit rise;
   } ev_t;

   logic CLOCK = 1'b0;
   logic rst;
   int   cyc;
   int   n_chk;
   int   n_err;
   logic [NCH-1:0] prev_key;
   ev_t  evq [NCH][$];

   g15_key_conditioner_if #(.N_CH(NCH)) bus ();

   g15_key_conditioner #(
      .N_CH        (NCH),
      .DEBOUNCE_MS (3),
      .HOLD_MS     (5),
      .CNT_W       (6)
   ) dut (
      .CLOCK (CLOCK),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Edge at which key_out goes high when the contact is first sampled at edge p:
   // 2 sync cycles, then the 3rd tick strictly after the QUAL entry edge.
   function automatic int t3(int p);
      return ((p + 2) / 100 + 1) * 100 + 200;
   endfunction

   task automatic exp_ev(int c, int cy, bit r);
      ev_t e;
      e.cyc  = cy;
      e.rise = r;
      evq[c].push_back(e);
   endtask

   task automatic mon();
      for (int c = 0; c < NCH; c++) begin
         logic rise, fall;
         ev_t  e;
         rise = bus.key_out[c] & ~prev_key[c];
         fall = ~bus.key_out[c] & prev_key[c];
         if (rise || fall) begin
            if (evq[c].size() == 0) begin
               chk($sformatf("ch%0d_unexpected", c), evq[c].size(), 1);
            end else begin
               e = evq[c].pop_front();
               chk($sformatf("ch%0d_kind", c), rise, e.rise);
               chk($sformatf("ch%0d_cycle", c), cyc, e.cyc);
            end
            if (rise) chk($sformatf("ch%0d_strobe", c), bus.key_edge[c], 1);
         end else if (bus.key_edge[c]) begin
            chk($sformatf("ch%0d_stray_edge", c), bus.key_edge[c], 0);
         end
      end
      prev_key = bus.key_out;
   endtask

   task automatic cyc_step();
      bus.tick_ms = ((cyc + 1) % 100 == 0);
      @(posedge CLOCK);
      #1;
      cyc++;
      mon();
   endtask

   task automatic run_to(int t);
      while (cyc < t) cyc_step();
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      cyc   = 0;
      prev_key = '0;
      rst = 1'b1;
      bus.tick_ms      = 1'b0;
      bus.raw_in       = '0;
      bus.mode_oneshot = '0;

      repeat (3) cyc_step();
      chk("rst_key_out",  bus.key_out,  0);
      chk("rst_key_edge", bus.key_edge, 0);
      chk("rst_busy",     bus.busy,     0);
      rst = 1'b0;

      // Level press on ch0.
      run_to(1030);
      bus.raw_in[0] = 1'b1;
      exp_ev(0, t3(cyc + 1), 1'b1);
      run_to(1040);
      chk("busy_qual", bus.busy, 1);
      run_to(3030);
      bus.raw_in[0] = 1'b0;
      exp_ev(0, t3(cyc + 1), 1'b0);
      run_to(3350);
      chk("busy_idle_lvl", bus.busy, 0);

      // Bounce on ch1: 30-cycle toggles for 4 ticks, then steady.
      run_to(3409);
      while (cyc < 3809) begin
         bus.raw_in[1] = (((cyc + 1 - 3410) / 30) % 2 == 0);
         cyc_step();
      end
      bus.raw_in[1] = 1'b1;
      exp_ev(1, t3(cyc + 1), 1'b1);
      run_to(4330);
      bus.raw_in[1] = 1'b0;
      exp_ev(1, t3(cyc + 1), 1'b0);
      run_to(4650);

      // One-shot lockout on ch2: held 50 ticks, single 5-tick pulse.
      bus.mode_oneshot[2] = 1'b1;
      run_to(4730);
      bus.raw_in[2] = 1'b1;
      exp_ev(2, t3(cyc + 1), 1'b1);
      exp_ev(2, t3(cyc + 1) + 500, 1'b0);
      run_to(9730);
      chk("busy_lockout", bus.busy, 1);
      bus.raw_in[2] = 1'b0;
      run_to(10050);
      chk("busy_after_lockout", bus.busy, 0);
      bus.raw_in[2] = 1'b1;
      exp_ev(2, t3(cyc + 1), 1'b1);
      exp_ev(2, t3(cyc + 1) + 500, 1'b0);
      run_to(11030);
      bus.raw_in[2] = 1'b0;
      run_to(11350);
      chk("busy_after_2nd", bus.busy, 0);
      bus.mode_oneshot[2] = 1'b0;

      // Simultaneous press, contacts rise on a tick cycle.
      run_to(11399);
      bus.raw_in = '1;
      for (int c = 0; c < NCH; c++) exp_ev(c, t3(cyc + 1), 1'b1);
      run_to(11700);
      chk("simul_edges", bus.key_edge, 4'hF);
      run_to(11930);
      bus.raw_in = '0;
      for (int c = 0; c < NCH; c++) exp_ev(c, t3(cyc + 1), 1'b0);
      run_to(12250);

      // Mode change while ch3 is ACTIVE in level mode: stays level.
      run_to(12330);
      bus.raw_in[3] = 1'b1;
      exp_ev(3, t3(cyc + 1), 1'b1);
      run_to(12650);
      bus.mode_oneshot[3] = 1'b1;
      run_to(13630);
      chk("mode_held_level", bus.key_out[3], 1);
      bus.raw_in[3] = 1'b0;
      exp_ev(3, t3(cyc + 1), 1'b0);
      run_to(13950);
      chk("busy_after_mode", bus.busy, 0);
      bus.mode_oneshot[3] = 1'b0;

      // Reset while ch2 one-shot is ACTIVE, contact kept closed.
      bus.mode_oneshot[2] = 1'b1;
      run_to(14030);
      bus.raw_in[2] = 1'b1;
      exp_ev(2, t3(cyc + 1), 1'b1);
      run_to(14350);
      chk("pre_rst_key", bus.key_out[2], 1);
      rst = 1'b1;
      #2;
      chk("rst_mid_key_out", bus.key_out, 0);
      chk("rst_mid_busy",    bus.busy,    0);
      exp_ev(2, cyc + 1, 1'b0);
      cyc_step();
      rst = 1'b0;
      exp_ev(2, t3(cyc + 1), 1'b1);
      exp_ev(2, t3(cyc + 1) + 500, 1'b0);
      run_to(15130);
      bus.raw_in[2] = 1'b0;
      run_to(15450);
      chk("busy_final", bus.busy, 0);

      for (int c = 0; c < NCH; c++)
         chk($sformatf("ch%0d_pending", c), evq[c].size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
